fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: stall  input  1  hold PC and IF/ID register contents.
REQ-005 Port: br_taken  input  1  branch resolved taken this cycle.
REQ-006 Port: br_offset  input  16  branch byte offset, signed, not shifted.
REQ-007 Port: br_pc4  input  32  PC+4 of the branch instruction.
REQ-008 Port: jmp  input  1  unconditional jump this cycle.
REQ-009 Port: jmp_index  input  26  jump byte-address field.
REQ-010 Port: imem_addr  output  32  address to instruction memory (equals PC).
REQ-011 Port: imem_data  input  32  combinational instruction word for imem_addr.
REQ-012 Port: ifid_instr  output  32  registered instruction to decode.
REQ-013 Port: ifid_pc4  output  32  registered PC+4 of ifid_instr.
REQ-014 Port: ifid_valid  output  1  ifid_instr is a real fetched instruction.
REQ-015 Port: misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-016 Port: fetch_count  output  16  count of instructions delivered into IF/ID.

Function
REQ-017 imem_addr SHALL equal the PC register combinationally; no extra latency.
REQ-018 Branch target SHALL be br_pc4 + sign_extend(br_offset), 32-bit, modulo 2^32.
REQ-019 Jump target SHALL be {br_pc4[31:26], jmp_index}.
REQ-020 Next-PC priority SHALL be: jmp > br_taken > stall (hold) > PC+4.
REQ-021 A redirect (jmp or br_taken) SHALL override stall in the same cycle.
REQ-022 On redirect, PC SHALL load target with bits [1:0] forced to 00; if the raw target bits [1:0] were nonzero, misalign_err SHALL set and remain set until reset.
REQ-023 On redirect, IF/ID SHALL be flushed: ifid_valid=0, ifid_instr=0 (nop), ifid_pc4=0.
REQ-024 On a normal advance (no redirect, no stall), IF/ID SHALL capture imem_data and PC+4, and set ifid_valid=1.
REQ-025 When stall=1 and there is no redirect, PC, IF/ID and fetch_count SHALL hold.
REQ-026 fetch_count SHALL increment by 1 on each normal advance and wrap from 16'hFFFF to 0.
REQ-027 PC+4 SHALL wrap from 32'hFFFFFFFC to 32'h00000000 without error.
REQ-028 Latency: an instruction at PC SHALL appear on ifid_instr 1 cycle after PC presents it with no stall.

Reset
REQ-029 While rst_n=0: PC=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, misalign_err=0, fetch_count=0.
REQ-030 Reset SHALL take effect asynchronously mid-operation, discarding any pending redirect or stall.
REQ-031 The first advance after rst_n deasserts SHALL fetch from RESET_PC.

Structure
REQ-032 The NOP encoding (32'h0) and the 4-byte instruction-step constant SHALL live in the shared CPU package.
REQ-033 Target computation SHALL be a combinational sub-module named next_pc_calc; PC, IF/ID and the counter SHALL stay in fetch_unit.

Verification
REQ-034 Reset then 3 free-running cycles with memory returning addi words -> imem_addr 0,4,8,C; ifid_pc4 4,8,C; fetch_count 3.
REQ-035 br_taken=1, br_pc4=0x0C, br_offset=0x0018 -> next imem_addr 0x24; ifid_valid=0 for 1 cycle; fetch_count unchanged in that cycle.
REQ-036 jmp=1, jmp_index=0x000004, br_pc4=0x28 -> next imem_addr 0x04; IF/ID flushed.
REQ-037 stall=1 for 2 cycles at PC 0x10 -> PC, ifid_instr and fetch_count unchanged; stall=1 with br_taken=1 in the same cycle -> the redirect still occurs.
REQ-038 br_pc4=0x08, br_offset=0x0002 -> PC=0x08 (bits [1:0] cleared); misalign_err=1 and stays 1 after later normal fetches.
REQ-039 rst_n pulsed low mid-cycle during a redirect -> outputs reach reset values immediately; first fetch after release from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants and the IF/ID pipeline register layout used by the fetch stage.
package fetch_unit_pkg;
  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [31:0] INSTR_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_FLUSH = '{instr: NOP, pc4: 32'h0, valid: 1'b0};
endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump > branch > stall hold > sequential step.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic [31:0] br_pc4,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        misalign
);
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] raw_target;

  assign pc_plus4   = pc + INSTR_STEP;
  assign br_target  = br_pc4 + {{16{br_offset[15]}}, br_offset};
  assign jmp_target = {br_pc4[31:26], jmp_index};
  assign redirect   = jmp | br_taken;
  assign raw_target = jmp ? jmp_target : br_target;
  assign misalign   = redirect & (raw_target[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    if (redirect)   next_pc = {raw_target[31:2], 2'b00};
    else if (stall) next_pc = pc;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, sticky misalign flag
// and delivered-instruction counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic [31:0] br_pc4,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        misalign_q, misalign_d;
  logic [15:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        misalign;

  next_pc_calc u_next_pc (
    .pc        (pc_q),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_offset (br_offset),
    .br_pc4    (br_pc4),
    .jmp       (jmp),
    .jmp_index (jmp_index),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc),
    .redirect  (redirect),
    .misalign  (misalign)
  );

  // A redirect wins over stall: the fetched slot is squashed and replaced by a bubble.
  always_comb begin
    pc_d       = next_pc;
    ifid_d     = ifid_q;
    count_d    = count_q;
    misalign_d = misalign_q | misalign;
    if (redirect) begin
      ifid_d = IFID_FLUSH;
    end else if (!stall) begin
      ifid_d  = '{instr: imem_data, pc4: pc_plus4, valid: 1'b1};
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ifid_q     <= IFID_FLUSH;
      misalign_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_instr   = ifid_q.instr;
  assign ifid_pc4     = ifid_q.pc4;
  assign ifid_valid   = ifid_q.valid;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model predicts each IF/ID slot and PC.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jmp;
  logic [15:0] br_offset;
  logic [31:0] br_pc4;
  logic [25:0] jmp_index;
  logic [31:0] imem_addr, imem_data, ifid_instr, ifid_pc4;
  logic        ifid_valid, misalign_err;
  logic [15:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;
  exp_t sb[$];

  // reference model state
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_mis;
  exp_t        m_ifid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0000 ^ a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_offset(br_offset), .br_pc4(br_pc4), .jmp(jmp), .jmp_index(jmp_index),
    .imem_addr(imem_addr), .imem_data(imem_data), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  task automatic model_reset();
    m_pc   = 32'h0;
    m_cnt  = 16'h0;
    m_mis  = 1'b0;
    m_ifid = '{instr: 32'h0, pc4: 32'h0, valid: 1'b0};
    sb.delete();
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    br_offset = 16'h0; br_pc4 = 32'h0; jmp_index = 26'h0;
  endtask

  task automatic check_reset_values(input string nm);
    n_tests++;
    if (imem_addr !== 32'h0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 ||
        ifid_valid !== 1'b0 || misalign_err !== 1'b0 || fetch_count !== 16'h0) begin
      n_fail++;
      $display("FAIL %s: got addr=%h instr=%h pc4=%h v=%b mis=%b cnt=%0d, want all zero",
               nm, imem_addr, ifid_instr, ifid_pc4, ifid_valid, misalign_err, fetch_count);
    end
  endtask

  // One clock with the given controls; model predicts, DUT is compared after the edge.
  task automatic cycle(input string nm, input logic s, input logic b, input logic [15:0] off,
                       input logic [31:0] p4, input logic j, input logic [25:0] idx);
    logic [31:0] t;
    exp_t e;
    stall = s; br_taken = b; br_offset = off; br_pc4 = p4; jmp = j; jmp_index = idx;
    #1;
    n_tests++;
    if (imem_addr !== m_pc) begin
      n_fail++;
      $display("FAIL %s/imem_addr_pre: got %h want %h", nm, imem_addr, m_pc);
    end
    if (j || b) begin
      t = j ? {p4[31:26], idx} : p4 + {{16{off[15]}}, off};
      if (t[1:0] != 2'b00) m_mis = 1'b1;
      m_pc   = t & 32'hFFFF_FFFC;
      m_ifid = '{instr: 32'h0, pc4: 32'h0, valid: 1'b0};
    end else if (!s) begin
      m_ifid = '{instr: mem_word(m_pc), pc4: m_pc + 32'd4, valid: 1'b1};
      m_pc   = m_pc + 32'd4;
      m_cnt  = m_cnt + 16'd1;
    end
    sb.push_back(m_ifid);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (ifid_instr !== e.instr) begin
      n_fail++; $display("FAIL %s/ifid_instr: got %h want %h", nm, ifid_instr, e.instr);
    end
    n_tests++;
    if (ifid_pc4 !== e.pc4) begin
      n_fail++; $display("FAIL %s/ifid_pc4: got %h want %h", nm, ifid_pc4, e.pc4);
    end
    n_tests++;
    if (ifid_valid !== e.valid) begin
      n_fail++; $display("FAIL %s/ifid_valid: got %b want %b", nm, ifid_valid, e.valid);
    end
    n_tests++;
    if (imem_addr !== m_pc) begin
      n_fail++; $display("FAIL %s/imem_addr: got %h want %h", nm, imem_addr, m_pc);
    end
    n_tests++;
    if (fetch_count !== m_cnt) begin
      n_fail++; $display("FAIL %s/fetch_count: got %0d want %0d", nm, fetch_count, m_cnt);
    end
    n_tests++;
    if (misalign_err !== m_mis) begin
      n_fail++; $display("FAIL %s/misalign_err: got %b want %b", nm, misalign_err, m_mis);
    end
    idle_inputs();
  endtask

  task automatic advance(input string nm);
    cycle(nm, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 26'h0);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset_hold");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    // first edge after release fetches RESET_PC
    n_tests++;
    if (ifid_pc4 !== 32'h4 || imem_addr !== 32'h4 || fetch_count !== 16'd1) begin
      n_fail++;
      $display("FAIL first_fetch: got pc4=%h addr=%h cnt=%0d want 4 4 1",
               ifid_pc4, imem_addr, fetch_count);
    end
    m_ifid = '{instr: mem_word(32'h0), pc4: 32'h4, valid: 1'b1};
    m_pc = 32'h4; m_cnt = 16'd1;
  endtask

  task automatic test_free_run();
    advance("free_run1");
    advance("free_run2");
    advance("free_run3");
  endtask

  task automatic test_branch();
    cycle("branch_fwd", 1'b0, 1'b1, 16'h0018, 32'h0000_000C, 1'b0, 26'h0);
    advance("after_branch");
    cycle("branch_neg", 1'b0, 1'b1, 16'hFFF0, 32'h0000_0040, 1'b0, 26'h0);
  endtask

  task automatic test_jump();
    cycle("jump", 1'b0, 1'b0, 16'h0, 32'h0000_0028, 1'b1, 26'h000004);
    advance("to_10_a");
    advance("to_10_b");
    advance("to_10_c");
  endtask

  task automatic test_stall();
    cycle("stall1", 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 26'h0);
    cycle("stall2", 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 26'h0);
    cycle("stall_br", 1'b1, 1'b1, 16'h0008, 32'h0000_0014, 1'b0, 26'h0);
    cycle("stall_jmp", 1'b1, 1'b1, 16'h0008, 32'h0000_0014, 1'b1, 26'h000100);
  endtask

  task automatic test_misalign();
    cycle("misalign_br", 1'b0, 1'b1, 16'h0002, 32'h0000_0008, 1'b0, 26'h0);
    advance("misalign_sticky1");
    advance("misalign_sticky2");
  endtask

  task automatic test_wrap();
    cycle("jump_top", 1'b0, 1'b0, 16'h0, 32'hFC00_0000, 1'b1, 26'h3FF_FFFC);
    advance("pc_wrap");
    advance("after_wrap");
  endtask

  task automatic test_async_reset();
    br_taken = 1'b1; br_pc4 = 32'h0000_0100; br_offset = 16'h0010; stall = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_reset_values("async_reset_now");
    model_reset();
    @(posedge clk); #1 check_reset_values("async_reset_edge");
    idle_inputs();
    #2 rst_n = 1'b1;
    advance("post_reset1");
    advance("post_reset2");
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_jump();
    test_stall();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
